// File: rtl/tx_arbiter_pkg.sv
// Shared types and constants for the TX link arbiter.
package tx_arbiter_pkg;

    // Width of a serial-engine command word.
    localparam int TX_CMD_BITS = 8;

    // Arbiter FSM encodings.
    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_SC   = 2'd1,
        ARB_PF   = 2'd2
    } arb_state_t;

    // Reply-owner tag stored in the reply queue.
    localparam logic OWNER_SC = 1'b0;
    localparam logic OWNER_PF = 1'b1;

endpackage

// File: rtl/tx_arbiter_if.sv
// Requester and serial-engine signals for the TX link arbiter.
// slave: the arbiter side; master: the requesters/engines side.
interface tx_arbiter_if
    import tx_arbiter_pkg::*;
#(
    parameter int NSHIFT = 2
);

    logic                   sc_reserve_tx;
    logic                   sc_cmd_valid;
    logic [TX_CMD_BITS-1:0] sc_cmd;
    logic                   sc_reply_wanted;
    logic                   sc_cmd_started;
    logic [NSHIFT-1:0]      sc_tx_data;
    logic                   sc_tx_data_next;
    logic                   sc_tx_done;
    logic                   sc_rx_started;
    logic                   sc_rx_data_valid;
    logic                   sc_rx_done;

    logic                   pf_cmd_valid;
    logic [TX_CMD_BITS-1:0] pf_cmd;
    logic                   pf_reply_wanted;
    logic                   pf_cmd_started;
    logic [NSHIFT-1:0]      pf_tx_data;
    logic                   pf_tx_data_next;
    logic                   pf_tx_done;
    logic                   pf_rx_started;
    logic                   pf_rx_data_valid;
    logic                   pf_rx_done;

    logic                   tx_command_valid;
    logic [TX_CMD_BITS-1:0] tx_command;
    logic                   tx_command_accept;
    logic [NSHIFT-1:0]      tx_data;
    logic                   tx_data_next;
    logic                   tx_done;
    logic                   rx_started;
    logic                   rx_data_valid;
    logic                   rx_done;

    logic                   link_idle;
    logic                   reply_error;

    modport slave (
        input  sc_reserve_tx, sc_cmd_valid, sc_cmd, sc_reply_wanted, sc_tx_data,
        output sc_cmd_started, sc_tx_data_next, sc_tx_done,
        output sc_rx_started, sc_rx_data_valid, sc_rx_done,
        input  pf_cmd_valid, pf_cmd, pf_reply_wanted, pf_tx_data,
        output pf_cmd_started, pf_tx_data_next, pf_tx_done,
        output pf_rx_started, pf_rx_data_valid, pf_rx_done,
        output tx_command_valid, tx_command, tx_data,
        input  tx_command_accept, tx_data_next, tx_done,
        input  rx_started, rx_data_valid, rx_done,
        output link_idle, reply_error
    );

    modport master (
        output sc_reserve_tx, sc_cmd_valid, sc_cmd, sc_reply_wanted, sc_tx_data,
        input  sc_cmd_started, sc_tx_data_next, sc_tx_done,
        input  sc_rx_started, sc_rx_data_valid, sc_rx_done,
        output pf_cmd_valid, pf_cmd, pf_reply_wanted, pf_tx_data,
        input  pf_cmd_started, pf_tx_data_next, pf_tx_done,
        input  pf_rx_started, pf_rx_data_valid, pf_rx_done,
        input  tx_command_valid, tx_command, tx_data,
        output tx_command_accept, tx_data_next, tx_done,
        output rx_started, rx_data_valid, rx_done,
        input  link_idle, reply_error
    );

endinterface

// File: rtl/tx_arbiter_reply_owner_fifo.sv
// 1-bit ring-buffer FIFO recording which requester owns each outstanding reply.
// A push and a pop in the same cycle are both honoured.
module reply_owner_fifo #(
    parameter int DEPTH = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic push,
    input  logic pop,
    input  logic din,
    output logic dout,
    output logic full,
    output logic empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [DEPTH-1:0] mem;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             do_push;
    logic             do_pop;

    // Pointers wrap modulo DEPTH, which need not be a power of two.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign dout    = mem[rd_ptr];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Storage, pointers and occupancy update.
    always_ff @(posedge clk) begin
        if (reset) begin
            mem    <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= ptr_inc(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/tx_arbiter.sv
// Shares the serial TX/RX link between the scheduler (fixed priority) and
// the prefetcher, and steers RX replies back in command order.
//
// state    | meaning
// ---------+----------------------------------------------------------
// ARB_IDLE | link free; grant evaluated combinationally each cycle
// ARB_SC   | scheduler owns TX payload until tx_done
// ARB_PF   | prefetcher owns TX payload until tx_done
module tx_arbiter
    import tx_arbiter_pkg::*;
#(
    parameter int NSHIFT          = 2,
    parameter int PAYLOAD_CYCLES  = 8,
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic         clk,
    input  logic         reset,
    tx_arbiter_if.slave  bus
);

    if (PAYLOAD_CYCLES < 1 || MAX_OUTSTANDING < 1 || MAX_OUTSTANDING > 4) begin : g_param_check
        $error("tx_arbiter: illegal parameter value");
    end

    arb_state_t             state;
    arb_state_t             state_nxt;
    logic                   q_push;
    logic                   q_pop;
    logic                   q_din;
    logic                   q_head;
    logic                   q_full;
    logic                   q_empty;
    logic                   sc_eligible;
    logic                   pf_eligible;
    logic [TX_CMD_BITS-1:0] cmd_mux;
    logic [NSHIFT-1:0]      data_mux;
    logic                   rx_any;

    reply_owner_fifo #(
        .DEPTH (MAX_OUTSTANDING)
    ) u_owner_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (q_push),
        .pop   (q_pop),
        .din   (q_din),
        .dout  (q_head),
        .full  (q_full),
        .empty (q_empty)
    );

    // Eligibility uses pre-pop occupancy so an rx_done cannot free a slot
    // for a grant in the same cycle.
    assign sc_eligible = bus.sc_cmd_valid && !(bus.sc_reply_wanted && q_full);
    assign pf_eligible = bus.pf_cmd_valid && !bus.sc_reserve_tx && !bus.sc_cmd_valid
                         && !(bus.pf_reply_wanted && q_full);

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ARB_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Grant, accept and payload routing for the current owner.
    always_comb begin
        state_nxt           = state;
        cmd_mux             = '0;
        data_mux            = '0;
        bus.tx_command_valid = 1'b0;
        bus.sc_cmd_started  = 1'b0;
        bus.pf_cmd_started  = 1'b0;
        bus.sc_tx_data_next = 1'b0;
        bus.pf_tx_data_next = 1'b0;
        bus.sc_tx_done      = 1'b0;
        bus.pf_tx_done      = 1'b0;
        q_push              = 1'b0;
        q_din               = OWNER_SC;
        case (state)
            ARB_IDLE: begin
                if (sc_eligible) begin
                    bus.tx_command_valid = 1'b1;
                    cmd_mux              = bus.sc_cmd;
                    if (bus.tx_command_accept) begin
                        bus.sc_cmd_started = 1'b1;
                        state_nxt          = ARB_SC;
                        q_push             = bus.sc_reply_wanted;
                        q_din              = OWNER_SC;
                    end
                end else if (pf_eligible) begin
                    bus.tx_command_valid = 1'b1;
                    cmd_mux              = bus.pf_cmd;
                    if (bus.tx_command_accept) begin
                        bus.pf_cmd_started = 1'b1;
                        state_nxt          = ARB_PF;
                        q_push             = bus.pf_reply_wanted;
                        q_din              = OWNER_PF;
                    end
                end
            end
            ARB_SC: begin
                data_mux            = bus.sc_tx_data;
                bus.sc_tx_data_next = bus.tx_data_next;
                bus.sc_tx_done      = bus.tx_done;
                if (bus.tx_done) begin
                    state_nxt = ARB_IDLE;
                end
            end
            ARB_PF: begin
                data_mux            = bus.pf_tx_data;
                bus.pf_tx_data_next = bus.tx_data_next;
                bus.pf_tx_done      = bus.tx_done;
                if (bus.tx_done) begin
                    state_nxt = ARB_IDLE;
                end
            end
            default: begin
                state_nxt = ARB_IDLE;
            end
        endcase
    end

    assign bus.tx_command = cmd_mux;
    assign bus.tx_data    = data_mux;

    // RX events follow the queue head; with an empty queue they go nowhere.
    assign rx_any               = bus.rx_started || bus.rx_data_valid || bus.rx_done;
    assign q_pop                = bus.rx_done && !q_empty;
    assign bus.sc_rx_started    = bus.rx_started    && !q_empty && (q_head == OWNER_SC);
    assign bus.sc_rx_data_valid = bus.rx_data_valid && !q_empty && (q_head == OWNER_SC);
    assign bus.sc_rx_done       = bus.rx_done       && !q_empty && (q_head == OWNER_SC);
    assign bus.pf_rx_started    = bus.rx_started    && !q_empty && (q_head == OWNER_PF);
    assign bus.pf_rx_data_valid = bus.rx_data_valid && !q_empty && (q_head == OWNER_PF);
    assign bus.pf_rx_done       = bus.rx_done       && !q_empty && (q_head == OWNER_PF);

    assign bus.link_idle = (state == ARB_IDLE) && q_empty;

    // Sticky flag for an RX event that has no outstanding owner.
    always_ff @(posedge clk) begin
        if (reset) begin
            bus.reply_error <= 1'b0;
        end else if (rx_any && q_empty) begin
            bus.reply_error <= 1'b1;
        end
    end

endmodule

// File: tb/tb_tx_arbiter.sv
// Directed bench for tx_arbiter with hand-computed expectations.
module tb_tx_arbiter;
    import tx_arbiter_pkg::*;

    logic clk = 1'b0;
    logic reset;
    int   n_assert = 0;
    int   n_fail   = 0;

    tx_arbiter_if #(.NSHIFT(2)) bus ();

    tx_arbiter #(
        .NSHIFT          (2),
        .PAYLOAD_CYCLES  (8),
        .MAX_OUTSTANDING (2)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.sc_reserve_tx     = 1'b0;
        bus.sc_cmd_valid      = 1'b0;
        bus.sc_cmd            = '0;
        bus.sc_reply_wanted   = 1'b0;
        bus.sc_tx_data        = '0;
        bus.pf_cmd_valid      = 1'b0;
        bus.pf_cmd            = '0;
        bus.pf_reply_wanted   = 1'b0;
        bus.pf_tx_data        = '0;
        bus.tx_command_accept = 1'b0;
        bus.tx_data_next      = 1'b0;
        bus.tx_done           = 1'b0;
        bus.rx_started        = 1'b0;
        bus.rx_data_valid     = 1'b0;
        bus.rx_done           = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_link_idle"}, 32'(bus.link_idle), 32'd1);
        check({tag, "_reply_error"}, 32'(bus.reply_error), 32'd0);
        check({tag, "_cmd_valid"}, 32'(bus.tx_command_valid), 32'd0);
        check({tag, "_tx_command"}, 32'(bus.tx_command), 32'd0);
        check({tag, "_tx_data"}, 32'(bus.tx_data), 32'd0);
        check({tag, "_started"}, 32'({bus.sc_cmd_started, bus.pf_cmd_started}), 32'd0);
    endtask

    initial begin
        clear_inputs();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        #1;
        check_reset_outputs("rst");

        // Prefetch-only command with a reply; accept on the third request cycle.
        bus.pf_cmd_valid    = 1'b1;
        bus.pf_cmd          = 8'h05;
        bus.pf_reply_wanted = 1'b1;
        #1;
        check("pf_valid", 32'(bus.tx_command_valid), 32'd1);
        check("pf_cmd", 32'(bus.tx_command), 32'h05);
        check("pf_no_start", 32'(bus.pf_cmd_started), 32'd0);
        step();
        step();
        bus.tx_command_accept = 1'b1;
        #1;
        check("pf_started", 32'(bus.pf_cmd_started), 32'd1);
        check("pf_sc_not_started", 32'(bus.sc_cmd_started), 32'd0);
        step();
        clear_inputs();
        bus.pf_tx_data = 2'b10;
        bus.sc_tx_data = 2'b01;
        #1;
        check("pftx_cmd_valid", 32'(bus.tx_command_valid), 32'd0);
        check("pftx_tx_data", 32'(bus.tx_data), 32'd2);
        check("pftx_link_idle", 32'(bus.link_idle), 32'd0);
        bus.tx_data_next = 1'b1;
        for (int i = 0; i < 8; i++) begin
            #1;
            check("pftx_next_pf", 32'(bus.pf_tx_data_next), 32'd1);
            check("pftx_next_sc", 32'(bus.sc_tx_data_next), 32'd0);
            step();
        end
        bus.tx_data_next = 1'b0;
        bus.tx_done      = 1'b1;
        #1;
        check("pftx_done_pf", 32'(bus.pf_tx_done), 32'd1);
        check("pftx_done_sc", 32'(bus.sc_tx_done), 32'd0);
        step();
        clear_inputs();
        #1;
        check("pf_after_done_idle", 32'(bus.link_idle), 32'd0);
        check("pf_after_done_tx_data", 32'(bus.tx_data), 32'd0);
        bus.rx_started = 1'b1;
        #1;
        check("pfrx_started", 32'({bus.pf_rx_started, bus.sc_rx_started}), 32'b10);
        step();
        bus.rx_started    = 1'b0;
        bus.rx_data_valid = 1'b1;
        #1;
        check("pfrx_valid", 32'({bus.pf_rx_data_valid, bus.sc_rx_data_valid}), 32'b10);
        step();
        bus.rx_data_valid = 1'b0;
        bus.rx_done       = 1'b1;
        #1;
        check("pfrx_done", 32'({bus.pf_rx_done, bus.sc_rx_done}), 32'b10);
        step();
        bus.rx_done = 1'b0;
        #1;
        check("pf_link_idle_after_pop", 32'(bus.link_idle), 32'd1);
        check("pf_no_error", 32'(bus.reply_error), 32'd0);

        // Simultaneous requests: scheduler wins, prefetch follows after tx_done.
        bus.sc_cmd_valid      = 1'b1;
        bus.sc_cmd            = 8'hA3;
        bus.pf_cmd_valid      = 1'b1;
        bus.pf_cmd            = 8'h05;
        bus.tx_command_accept = 1'b1;
        #1;
        check("prio_cmd", 32'(bus.tx_command), 32'hA3);
        check("prio_started", 32'({bus.sc_cmd_started, bus.pf_cmd_started}), 32'b10);
        step();
        bus.sc_cmd_valid = 1'b0;
        bus.sc_tx_data   = 2'b11;
        bus.pf_tx_data   = 2'b01;
        #1;
        check("sctx_valid", 32'(bus.tx_command_valid), 32'd0);
        check("sctx_tx_data", 32'(bus.tx_data), 32'd3);
        bus.tx_data_next = 1'b1;
        #1;
        check("sctx_next", 32'({bus.sc_tx_data_next, bus.pf_tx_data_next}), 32'b10);
        bus.tx_data_next = 1'b0;
        bus.tx_done      = 1'b1;
        #1;
        check("sctx_done", 32'({bus.sc_tx_done, bus.pf_tx_done}), 32'b10);
        check("sctx_no_b2b", 32'(bus.pf_cmd_started), 32'd0);
        step();
        bus.tx_done = 1'b0;
        #1;
        check("prio_pf_started", 32'(bus.pf_cmd_started), 32'd1);
        check("prio_pf_cmd", 32'(bus.tx_command), 32'h05);
        step();
        clear_inputs();
        bus.tx_done = 1'b1;
        step();
        bus.tx_done = 1'b0;
        #1;
        check("prio_link_idle", 32'(bus.link_idle), 32'd1);

        // Reserve holds prefetch off.
        bus.sc_reserve_tx     = 1'b1;
        bus.pf_cmd_valid      = 1'b1;
        bus.pf_cmd            = 8'h44;
        bus.tx_command_accept = 1'b1;
        for (int i = 0; i < 10; i++) begin
            #1;
            check("rsv_valid", 32'(bus.tx_command_valid), 32'd0);
            step();
        end
        bus.sc_reserve_tx = 1'b0;
        #1;
        check("rsv_drop_started", 32'(bus.pf_cmd_started), 32'd1);
        check("rsv_drop_cmd", 32'(bus.tx_command), 32'h44);
        step();
        clear_inputs();
        bus.sc_reserve_tx = 1'b1;
        #1;
        check("rsv_no_abort_valid", 32'(bus.tx_command_valid), 32'd0);
        bus.tx_done = 1'b1;
        #1;
        check("rsv_no_abort_done", 32'(bus.pf_tx_done), 32'd1);
        step();
        clear_inputs();

        // Fill the reply queue: pf then sc, both wanting replies.
        bus.pf_cmd_valid      = 1'b1;
        bus.pf_cmd            = 8'h11;
        bus.pf_reply_wanted   = 1'b1;
        bus.tx_command_accept = 1'b1;
        step();
        clear_inputs();
        bus.tx_done = 1'b1;
        step();
        clear_inputs();
        bus.sc_cmd_valid      = 1'b1;
        bus.sc_cmd            = 8'h22;
        bus.sc_reply_wanted   = 1'b1;
        bus.tx_command_accept = 1'b1;
        #1;
        check("fill_sc_started", 32'(bus.sc_cmd_started), 32'd1);
        step();
        clear_inputs();
        bus.tx_done = 1'b1;
        step();
        clear_inputs();
        bus.sc_cmd_valid      = 1'b1;
        bus.sc_cmd            = 8'h22;
        bus.sc_reply_wanted   = 1'b1;
        bus.tx_command_accept = 1'b1;
        #1;
        check("full_rw_valid", 32'(bus.tx_command_valid), 32'd0);
        check("full_rw_started", 32'(bus.sc_cmd_started), 32'd0);
        bus.sc_reply_wanted = 1'b0;
        #1;
        check("full_norw_valid", 32'(bus.tx_command_valid), 32'd1);
        check("full_norw_started", 32'(bus.sc_cmd_started), 32'd1);
        step();
        clear_inputs();
        bus.tx_done = 1'b1;
        step();
        clear_inputs();

        // rx_done with a reply-wanted request while full: grant waits one cycle.
        bus.pf_cmd_valid      = 1'b1;
        bus.pf_cmd            = 8'h33;
        bus.pf_reply_wanted   = 1'b1;
        bus.tx_command_accept = 1'b1;
        bus.rx_done           = 1'b1;
        #1;
        check("pop_push_rx_pf", 32'({bus.pf_rx_done, bus.sc_rx_done}), 32'b10);
        check("pop_push_blocked", 32'(bus.tx_command_valid), 32'd0);
        check("pop_push_no_start", 32'(bus.pf_cmd_started), 32'd0);
        step();
        bus.rx_done = 1'b0;
        #1;
        check("pop_push_granted", 32'(bus.pf_cmd_started), 32'd1);
        check("pop_push_cmd", 32'(bus.tx_command), 32'h33);
        step();
        clear_inputs();
        bus.tx_done = 1'b1;
        step();
        clear_inputs();
        bus.rx_done = 1'b1;
        #1;
        check("order_second_sc", 32'({bus.pf_rx_done, bus.sc_rx_done}), 32'b01);
        step();
        #1;
        check("order_third_pf", 32'({bus.pf_rx_done, bus.sc_rx_done}), 32'b10);
        step();
        bus.rx_done = 1'b0;
        #1;
        check("order_link_idle", 32'(bus.link_idle), 32'd1);
        check("order_no_error", 32'(bus.reply_error), 32'd0);

        // Push and pop of the last entry together leave only the pushed owner.
        bus.sc_cmd_valid      = 1'b1;
        bus.sc_reply_wanted   = 1'b1;
        bus.tx_command_accept = 1'b1;
        step();
        clear_inputs();
        bus.tx_done = 1'b1;
        step();
        clear_inputs();
        bus.pf_cmd_valid      = 1'b1;
        bus.pf_reply_wanted   = 1'b1;
        bus.tx_command_accept = 1'b1;
        bus.rx_done           = 1'b1;
        #1;
        check("swap_pop_sc", 32'({bus.pf_rx_done, bus.sc_rx_done}), 32'b01);
        check("swap_push_pf", 32'(bus.pf_cmd_started), 32'd1);
        step();
        clear_inputs();
        bus.tx_done = 1'b1;
        step();
        clear_inputs();
        bus.rx_started = 1'b1;
        #1;
        check("swap_head_pf", 32'({bus.pf_rx_started, bus.sc_rx_started}), 32'b10);
        bus.rx_started = 1'b0;
        bus.rx_done    = 1'b1;
        step();
        bus.rx_done = 1'b0;
        #1;
        check("swap_link_idle", 32'(bus.link_idle), 32'd1);

        // RX event with an empty queue.
        bus.rx_started = 1'b1;
        #1;
        check("empty_rx_routed", 32'({bus.pf_rx_started, bus.sc_rx_started}), 32'b00);
        step();
        bus.rx_started = 1'b0;
        #1;
        check("empty_error_set", 32'(bus.reply_error), 32'd1);
        step();
        check("empty_error_sticky", 32'(bus.reply_error), 32'd1);

        // Reset in the middle of a scheduler transfer.
        bus.sc_cmd_valid      = 1'b1;
        bus.sc_cmd            = 8'h7E;
        bus.sc_reply_wanted   = 1'b1;
        bus.tx_command_accept = 1'b1;
        step();
        clear_inputs();
        bus.sc_tx_data = 2'b11;
        #1;
        check("midrst_busy", 32'(bus.link_idle), 32'd0);
        check("midrst_tx_data", 32'(bus.tx_data), 32'd3);
        reset = 1'b1;
        step();
        check_reset_outputs("midrst");
        reset = 1'b0;
        step();
        check("midrst_queue_cleared", 32'(bus.link_idle), 32'd1);
        bus.rx_done = 1'b1;
        #1;
        check("midrst_no_owner", 32'({bus.pf_rx_done, bus.sc_rx_done}), 32'b00);
        step();
        clear_inputs();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
